bf16_addsub_sched: RTL

Scheduler that shares one bfloat16 add/sub datapath between two requesters. Each requester presents operands A/B and an operation bit over a valid/ready handshake. The block grants requesters round-robin and issues one operation at a time to the shared unit with a start/done handshake. It returns the result tagged with the requester ID, and guards the unit with a done-timeout.

---
 rtl/bf16_addsub_sched.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/bf16_addsub_sched.sv
// Round-robin scheduler sharing one bf16 add/sub unit between two requesters.
// Operands and results pass through bit-exact, and the unit is guarded by a done-timeout.
module bf16_addsub_sched #(
  parameter int unsigned TIMEOUT = 15
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        req0_valid_i,
  output logic        req0_ready_o,
  input  logic [15:0] req0_a_i,
  input  logic [15:0] req0_b_i,
  input  logic        req0_op_i,
  input  logic        req1_valid_i,
  output logic        req1_ready_o,
  input  logic [15:0] req1_a_i,
  input  logic [15:0] req1_b_i,
  input  logic        req1_op_i,
  output logic        rsp_valid_o,
  input  logic        rsp_ready_i,
  output logic        rsp_id_o,
  output logic [15:0] rsp_data_o,
  output logic        rsp_err_o,
  output logic        fpu_start_o,
  output logic [15:0] fpu_a_o,
  output logic [15:0] fpu_b_o,
  output logic        fpu_inst_o,
  input  logic        fpu_done_i,
  input  logic [15:0] fpu_result_i,
  output logic        busy_o
);

  localparam int unsigned CntW = $clog2(TIMEOUT + 1);
  localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT - 1);
  localparam logic [15:0] ErrNan = 16'h7FC0;

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StIssue = 2'd1;
  localparam logic [1:0] StWait  = 2'd2;
  localparam logic [1:0] StResp  = 2'd3;

  logic [1:0]      state_q, state_d;
  logic            last_q, last_d;
  logic            id_q, id_d;
  logic            op_q, op_d;
  logic [15:0]     a_q, a_d, b_q, b_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [15:0]     rdata_q, rdata_d;
  logic            rerr_q, rerr_d;

  logic gnt_vld, gnt_id;
  logic in_idle, drive_fpu, in_resp;

  assign in_idle   = (state_q == StIdle);
  assign in_resp   = (state_q == StResp);
  assign drive_fpu = (state_q == StIssue) || (state_q == StWait);

  // On a tie the requester that did not win last time is granted.
  always_comb begin
    gnt_vld = req0_valid_i | req1_valid_i;
    if (req0_valid_i && req1_valid_i) begin
      gnt_id = ~last_q;
    end else begin
      gnt_id = req1_valid_i;
    end
  end

  assign req0_ready_o = in_idle && gnt_vld && !gnt_id;
  assign req1_ready_o = in_idle && gnt_vld && gnt_id;

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    id_d    = id_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    cnt_d   = cnt_q;
    rdata_d = rdata_q;
    rerr_d  = rerr_q;
    case (state_q)
      StIdle: begin
        if (gnt_vld) begin
          id_d    = gnt_id;
          last_d  = gnt_id;
          a_d     = gnt_id ? req1_a_i : req0_a_i;
          b_d     = gnt_id ? req1_b_i : req0_b_i;
          op_d    = gnt_id ? req1_op_i : req0_op_i;
          state_d = StIssue;
        end
      end
      StIssue: begin
        cnt_d   = '0;
        state_d = StWait;
      end
      StWait: begin
        cnt_d = cnt_q + CntW'(1);
        // A done arriving in the last WAIT cycle beats the timeout.
        if (fpu_done_i) begin
          rdata_d = fpu_result_i;
          rerr_d  = 1'b0;
          state_d = StResp;
        end else if (cnt_q == CntLast) begin
          rdata_d = ErrNan;
          rerr_d  = 1'b1;
          state_d = StResp;
        end
      end
      StResp: begin
        if (rsp_ready_i) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= StIdle;
      last_q  <= 1'b1;
      id_q    <= 1'b0;
      op_q    <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      cnt_q   <= '0;
      rdata_q <= '0;
      rerr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      id_q    <= id_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      rerr_q  <= rerr_d;
    end
  end

  assign fpu_start_o = (state_q == StIssue);
  assign fpu_a_o     = drive_fpu ? a_q : '0;
  assign fpu_b_o     = drive_fpu ? b_q : '0;
  assign fpu_inst_o  = drive_fpu && op_q;

  assign rsp_valid_o = in_resp;
  assign rsp_id_o    = in_resp && id_q;
  assign rsp_data_o  = in_resp ? rdata_q : '0;
  assign rsp_err_o   = in_resp && rerr_q;

  assign busy_o = !in_idle;

endmodule
